// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption round controller.
// Owns the 128-bit state register and runs the initial AddRoundKey plus NR
// rounds at one round per clock. SubBytes+ShiftRows is external and is reached
// through sr_out/sr_in. Round keys come from an external store addressed by rk_idx.
// Optional feature macro: AES_CTRL_BLKCNT_EN adds a 32-bit completed-block counter (blk_cnt).
// Also contains the combinational mix_column used in rounds 1..NR-1.

module aes_round_ctrl #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [IDX_W-1:0]  rk_idx,
  input  logic [127:0]      rk,
  output logic [127:0]      sr_out,
  input  logic [127:0]      sr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data
`ifdef AES_CTRL_BLKCNT_EN
  ,
  output logic [31:0]       blk_cnt
`endif
);

  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } fsm_t;

  fsm_t              fsm_q;
  fsm_t              fsm_d;
  logic [3:0]        round_q;
  logic [DATA_W-1:0] state_p0;
  logic [DATA_W-1:0] mc_p0;

  // Column mixing of the SubBytes+ShiftRows result, used in rounds 1..NR-1
  mix_column u_mix (
    .in1 (sr_in),
    .s3  (mc_p0)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state logic: accept, NR-1 full rounds, final round, hold until consumed
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = RND;
      RND:     if (round_q == 4'(NR - 1)) fsm_d = FIN;
      FIN:     fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Output decode: handshakes and the round-key index requested this cycle
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = '0;
    case (fsm_q)
      IDLE:    in_ready  = 1'b1;
      RND:     rk_idx    = IDX_W'(round_q);
      FIN:     rk_idx    = IDX_W'(NR);
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Round counter: 1 after accept, saturates at NR in the final round, cleared on hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE:    if (in_valid) round_q <= 4'd1;
        RND:     round_q <= round_q + 4'd1;
        DONE:    if (out_ready) round_q <= '0;
        default: ;
      endcase
    end
  end

  // State register: AddRoundKey on accept, full rounds, then final round without mixing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= '0;
    end else begin
      case (fsm_q)
        IDLE:    if (in_valid) state_p0 <= in_data ^ rk;
        RND:     state_p0 <= mc_p0 ^ rk;
        FIN:     state_p0 <= sr_in ^ rk;
        default: ;
      endcase
    end
  end

  assign sr_out   = state_p0;
  assign out_data = state_p0;

`ifdef AES_CTRL_BLKCNT_EN
  // Completed-block counter, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// Combinational AES MixColumns over all four columns.
// Byte 0 is [127:120]; bytes are column-major, so column c occupies [127-32c -: 32].
module mix_column (
  input  logic [127:0] in1,
  output logic [127:0] s3
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = in1[127-32*c -: 8];
    assign a1 = in1[119-32*c -: 8];
    assign a2 = in1[111-32*c -: 8];
    assign a3 = in1[103-32*c -: 8];
    assign s3[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign s3[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign s3[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign s3[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl.
// Provides the external S-box/ShiftRows block and a key store, and compares
// the controller against a whole-cipher AES-128 reference computed in the bench.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] sr_out;
  logic [127:0] sr_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_CTRL_BLKCNT_EN
  logic [31:0]  blk_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0]   sbox   [0:255];
  logic [127:0] rk_tab [0:15];

  aes_round_ctrl #(.NR(10), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .sr_out    (sr_out),
    .sr_in     (sr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AES_CTRL_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External SubBytes+ShiftRows: out(r,c) = S(in(r,(c+r)%4))
  always_comb begin
    sr_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr_in[127-8*(r+4*c) -: 8] = sbox[sr_out[127-8*(r+4*((c+r)%4)) -: 8]];
  end

  // External key store
  always_comb rk = rk_tab[rk_idx];

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox[gb(s, r + 4*((c+r)%4))];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = gb(s, r + 4*c);
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4])
                                ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  // Whole-block reference cipher using the currently loaded key schedule
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk_tab[0];
    for (int r = 1; r < 10; r++) s = mix_cols(sub_shift(s)) ^ rk_tab[r];
    return sub_shift(s) ^ rk_tab[10];
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Push one block from IDLE, check latency and ciphertext, then drain with a ready delay
  task automatic run_block(input string nm, input logic [127:0] pt,
                           input logic [127:0] exp_ct, input int delay);
    int           lat;
    logic [127:0] held;
    chk({nm, " in_ready before accept"}, 128'(in_ready), 128'd1);
    in_data  = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 128'(lat), 128'd11);
    chk({nm, " ciphertext"}, out_data, exp_ct);
    held = out_data;
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({nm, " held data"}, out_data, held);
      chk({nm, " held in_ready"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [3];
    logic [127:0] ct1, key, pt;
    int           cyc1, seen, w;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    vecs[0] = '{"appB", APPB_KEY, APPB_PT, APPB_CT};
    vecs[1] = '{"zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[2] = '{"appC", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    set_key(128'h0);
    tick();
    tick();
    chk("rst in_ready", 128'(in_ready), 128'd1);
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst out_data", out_data, 128'h0);
    chk("rst rk_idx", 128'(rk_idx), 128'd0);
    chk("rst sr_out", sr_out, 128'h0);
    rst = 1'b0;
    tick();

    // Table-driven known-answer vectors
    for (int v = 0; v < 3; v++) begin
      set_key(vecs[v].key);
      chk({vecs[v].name, " model"}, aes_ref(vecs[v].pt), vecs[v].ct);
      run_block(vecs[v].name, vecs[v].pt, vecs[v].ct, v);
    end

    // App. B with intermediate states, rk_idx trace and backpressure
    set_key(APPB_KEY);
    in_data  = APPB_PT;
    in_valid = 1'b1;
    chk("trace idx accept", 128'(rk_idx), 128'd0);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk("trace rk_idx", 128'(rk_idx), 128'(k));
      chk("trace out_valid low", 128'(out_valid), 128'd0);
      if (k == 1) chk("state after E0", sr_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      if (k == 2) chk("state after E1", sr_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
      tick();
    end
    chk("trace out_valid", 128'(out_valid), 128'd1);
    chk("trace idx done", 128'(rk_idx), 128'd0);
    chk("trace ct", out_data, APPB_CT);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp data", out_data, APPB_CT);
      chk("bp out_valid", 128'(out_valid), 128'd1);
      chk("bp in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp idle in_ready", 128'(in_ready), 128'd1);
    chk("bp not accepted early", sr_out, APPB_CT);
    tick();
    in_valid = 1'b0;
    chk("bp accepted after idle", 128'(rk_idx), 128'd1);
    chk("bp new state", sr_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // Reset in the middle of a block, with a competing in_valid
    w = 0;
    while (rk_idx != 4'd5 && w < 20) begin
      tick();
      w++;
    end
    chk("reach round 5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst in_ready", 128'(in_ready), 128'd1);
    chk("midrst out_valid", 128'(out_valid), 128'd0);
    chk("midrst out_data", out_data, 128'h0);
    chk("midrst rk_idx", 128'(rk_idx), 128'd0);
    run_block("after rst", APPB_PT, APPB_CT, 0);

    // Back-to-back with both handshakes tied high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_data   = APPB_PT;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    seen = 0; cyc1 = 0; ct1 = '0; w = 0;
    while (seen < 2 && w < 60) begin
      tick();
      w++;
      if (out_valid) begin
        seen++;
`ifdef AES_CTRL_BLKCNT_EN
        chk("b2b blk_cnt before", 128'(blk_cnt), 128'(seen - 1));
`endif
        if (seen == 1) begin
          cyc1 = cyc;
          ct1  = out_data;
        end else begin
          chk("b2b spacing", 128'(cyc - cyc1), 128'd12);
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b count", 128'(seen), 128'd2);
    chk("b2b ct1", ct1, APPB_CT);
    chk("b2b ct2", out_data, APPB_CT);
    tick();
    out_ready = 1'b0;
    chk("b2b idle", 128'(in_ready), 128'd1);
`ifdef AES_CTRL_BLKCNT_EN
    chk("b2b blk_cnt after", 128'(blk_cnt), 128'd2);
`endif

    // Random keys, plaintexts, backpressure and idle gaps against the reference
    for (int n = 0; n < 16; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      run_block("rand", pt, aes_ref(pt), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
